conv_loop_sched: RTL

- Sequences one convolution tile pass as a 3-level nested loop: output-channel, then row, then column (column innermost).
- For each iteration it issues a one-cycle start pulse to the compute engine with the current indices, then waits for the engine's done.
- After the last iteration it returns a done pulse to the top-level controller.
- Sits between the layer controller and the PE-array/address-generation counters; it replaces free-running enables with an explicit start/done handshake.

---
 rtl/conv_loop_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/conv_loop_sched.sv
// Start/done sequencer for one convolution tile pass: channel -> row -> column loop nest.
// Define CONV_LOOP_SCHED_PAUSE_EN to add a pause input that stalls the loop in ADVANCE.
module conv_loop_sched #(
    parameter int unsigned CW      = 16,
    parameter int unsigned CH_MAX  = 4,
    parameter int unsigned ROW_MAX = 8,
    parameter int unsigned COL_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          eng_done,
`ifdef CONV_LOOP_SCHED_PAUSE_EN
    input  logic          pause,
`endif
    output logic          eng_start,
    output logic [CW-1:0] ch_idx,
    output logic [CW-1:0] row_idx,
    output logic [CW-1:0] col_idx,
    output logic [CW-1:0] iter_cnt,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] CH_LAST  = CW'(CH_MAX - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(ROW_MAX - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_FINISH  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          eng_start_q;
    logic          busy_q;
    logic          done_q;
    logic          hold_c;
    logic          last_c;

`ifdef CONV_LOOP_SCHED_PAUSE_EN
    assign hold_c = pause;
`else
    assign hold_c = 1'b0;
`endif

    assign last_c = (ch_q == CH_LAST) && (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Next-state and loop-index update
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        row_d   = row_q;
        col_d   = col_q;
        iter_d  = iter_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    iter_d  = '0;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    iter_d = iter_q + CW'(1);
                    if (last_c) begin
                        state_d = S_FINISH;
                        ch_d    = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        state_d = S_ADVANCE;
                    end
                end
            end
            S_ADVANCE: begin
                if (!hold_c) begin
                    state_d = S_ISSUE;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            ch_d  = ch_q + CW'(1);
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel overrides everything, including a coincident eng_done
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ch_d    = '0;
            row_d   = '0;
            col_d   = '0;
            iter_d  = iter_q;
        end
    end

    // State, indices and outputs, all registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            iter_q      <= '0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            row_q       <= row_d;
            col_q       <= col_d;
            iter_q      <= iter_d;
            eng_start_q <= (state_d == S_ISSUE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FINISH);
        end
    end

    assign eng_start = eng_start_q;
    assign ch_idx    = ch_q;
    assign row_idx   = row_q;
    assign col_idx   = col_q;
    assign iter_cnt  = iter_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
